dram_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single-port data RAM between NREQ requesters
//  (processor cores plus host loader). Each requester drives its memREAD/memWRITE,

---
 rtl/dram_arbiter_pkg.sv | 37 +++
 rtl/dram_arbiter_rr_pick.sv | 58 +++++
 rtl/dram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dram_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared types for the data-RAM arbiter.
//  - req_id_t    : requester id (3 bits, enough for up to 8 requesters)
//  - arb_state_e : arbiter FSM states (encoding 3 is unused and recovers to IDLE)
//  - ARB_OP_*    : operation encoding stored with a grant
//  - grant_t     : registered grant (winner id, op, rd+wr conflict flag)
package dram_arbiter_pkg;

    localparam int unsigned ID_W = 3;

    typedef logic [ID_W-1:0] req_id_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ISSUE  = 2'd1,
        ARB_RDWAIT = 2'd2
    } arb_state_e;

    localparam logic ARB_OP_RD = 1'b0;
    localparam logic ARB_OP_WR = 1'b1;

    typedef struct packed {
        req_id_t id;
        logic    op;
        logic    conflict;
    } grant_t;

    // Id of the requester after 'id', wrapping explicitly at nreq-1 -> 0.
    function automatic req_id_t next_id(input req_id_t id, input int unsigned nreq);
        int unsigned nxt;
        nxt = 32'(id) + 32'd1;
        if (nxt >= nreq) begin
            nxt = 32'd0;
        end
        return ID_W'(nxt);
    endfunction

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational round-robin picker.
//  act_i : per-requester active vector
//  ptr_i : requester with highest priority this round
//  win_o : first active requester found searching upward from ptr_i, mod NREQ
//  any_o : at least one requester is active
// Rotates act_i so ptr_i lands at position 0, priority-encodes, then un-rotates.
module dram_arbiter_rr_pick
    import dram_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0] act_i,
    input  req_id_t         ptr_i,
    output req_id_t         win_o,
    output logic            any_o
);

    logic [NREQ-1:0] rot;
    req_id_t         idx;
    int unsigned     off;
    logic            found;

    // base + offset modulo NREQ; both operands are below NREQ so one subtract suffices.
    function automatic req_id_t wrap_add(input req_id_t base, input int unsigned ofs);
        int unsigned s;
        s = 32'(base) + ofs;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return ID_W'(s);
    endfunction

    always_comb begin
        rot   = '0;
        idx   = '0;
        off   = 0;
        found = 1'b0;
        // rotate
        for (int unsigned j = 0; j < NREQ; j++) begin
            idx = wrap_add(ptr_i, j);
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (ID_W'(k) == idx) begin
                    rot[j] = act_i[k];
                end
            end
        end
        // priority encode, lowest rotated position wins
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                off   = j;
            end
        end
        any_o = found;
        win_o = wrap_add(ptr_i, off);
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between NREQ requesters.
//  Clk, Rst_n          : clock, asynchronous active-low reset
//  req_rd/req_wr       : per-requester level requests, held until done
//  req_addr/req_wdata  : packed per-requester address / write data
//  done/err            : one-cycle completion pulse; err flags a rd+wr conflict
//  rdata               : read data, updated when a read completes
//  mem_*               : registered RAM port; mem_rdata arrives the cycle after mem_read
//  busy                : arbiter is not IDLE
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [NREQ-1:0]         req_rd,
    input  logic [NREQ-1:0]         req_wr,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH-1:0]        rdata,
    output logic [NREQ-1:0]         err,
    output logic [AW-1:0]           mem_addr,
    output logic [WIDTH-1:0]        mem_wdata,
    output logic                    mem_read,
    output logic                    mem_write,
    input  logic [WIDTH-1:0]        mem_rdata,
    output logic                    busy
);

    arb_state_e      state_q, state_d;
    grant_t          grant_q, grant_d;
    req_id_t         ptr_q, ptr_d;

    logic [NREQ-1:0] act_c;
    req_id_t         pick_win;
    logic            pick_any;

    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             sel_rd, sel_wr;
    logic [NREQ-1:0]  win_vec;

    logic [NREQ-1:0]  done_d, err_d;
    logic [WIDTH-1:0] rdata_d, mem_wdata_d;
    logic [AW-1:0]    mem_addr_d;
    logic             mem_read_d, mem_write_d, busy_d;

    // A requester seeing its done pulse is still holding its old request; mask it.
    assign act_c = (req_rd | req_wr) & ~done;

    dram_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .act_i (act_c),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .any_o (pick_any)
    );

    // Request mux for the picked requester, and one-hot of the registered winner.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        win_vec   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == pick_win) begin
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*WIDTH +: WIDTH];
                sel_rd    = req_rd[i];
                sel_wr    = req_wr[i];
            end
            win_vec[i] = (ID_W'(i) == grant_q.id);
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (pick_any) state_d = ARB_ISSUE;
            ARB_ISSUE:  state_d = (grant_q.op == ARB_OP_WR) ? ARB_IDLE : ARB_RDWAIT;
            ARB_RDWAIT: state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        done_d      = '0;
        err_d       = '0;
        rdata_d     = rdata;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    // A rd+wr conflict is served as a write.
                    grant_d.id       = pick_win;
                    grant_d.op       = sel_wr ? ARB_OP_WR : ARB_OP_RD;
                    grant_d.conflict = sel_rd & sel_wr;
                    mem_addr_d       = sel_addr;
                    mem_wdata_d      = sel_wdata;
                    mem_write_d      = sel_wr;
                    mem_read_d       = ~sel_wr;
                end
            end
            ARB_ISSUE: begin
                ptr_d = next_id(grant_q.id, NREQ);
                if (grant_q.op == ARB_OP_WR) begin
                    done_d = win_vec;
                    err_d  = grant_q.conflict ? win_vec : '0;
                end
            end
            ARB_RDWAIT: begin
                done_d  = win_vec;
                rdata_d = mem_rdata;
            end
            default: ;
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    // Registered outputs and grant/pointer state.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            grant_q   <= '0;
            ptr_q     <= '0;
            done      <= '0;
            err       <= '0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            done      <= done_d;
            err       <= err_d;
            rdata     <= rdata_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: vector table, directed corner sequences, and a
// randomized run checked against a transaction-level reference model.
module tb_dram_arbiter;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned AW          = 8;
    localparam int unsigned NREQ        = 4;
    localparam int unsigned RAND_CYCLES = 1500;

    logic                  Clk;
    logic                  Rst_n;
    logic [NREQ-1:0]       req_rd, req_wr;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       done, err;
    logic [WIDTH-1:0]      rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]         mem_addr;
    logic                  mem_read, mem_write, busy;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    dram_arbiter #(.WIDTH(WIDTH), .AW(AW), .NREQ(NREQ)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Single-port RAM with a bench-side load port.
    logic [7:0] ram [256];
    logic       ld_en;
    logic [7:0] ld_addr, ld_data;
    always @(posedge Clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (mem_write) ram[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= ram[mem_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic set_req(input int id, input logic rd, input logic wr,
                           input logic [7:0] addr, input logic [7:0] wd);
        req_rd[id] = rd;
        req_wr[id] = wr;
        req_addr[id*AW +: AW] = addr;
        req_wdata[id*WIDTH +: WIDTH] = wd;
    endtask

    task automatic do_reset();
        req_rd = '0;
        req_wr = '0;
        ld_en  = 1'b0;
        Rst_n  = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge Clk);
        #1 ld_en = 1'b0;
    endtask

    // One isolated transaction from IDLE; lat counts edges from the sampling edge to done.
    task automatic run_one(input string name, input int id, input logic rd, input logic wr,
                           input logic [7:0] addr, input logic [7:0] wd,
                           input logic [3:0] e_done, input logic [3:0] e_err,
                           input logic [7:0] e_rdata, input int e_lat);
        int n = 0;
        bit seen = 1'b0;
        set_req(id, rd, wr, addr, wd);
        while (!seen && n < 8) begin
            @(posedge Clk);
            #1 n++;
            if (n == 1) begin
                chk({name, "/mem_write"}, 32'(mem_write), 32'(wr));
                chk({name, "/mem_read"}, 32'(mem_read), 32'(!wr));
                chk({name, "/mem_addr"}, 32'(mem_addr), 32'(addr));
                if (wr) chk({name, "/mem_wdata"}, 32'(mem_wdata), 32'(wd));
                chk({name, "/busy"}, 32'(busy), 32'd1);
            end
            if (done != '0) seen = 1'b1;
        end
        set_req(id, 1'b0, 1'b0, addr, wd);
        chk({name, "/latency"}, 32'(n), 32'(e_lat));
        chk({name, "/done"}, 32'(done), 32'(e_done));
        chk({name, "/err"}, 32'(err), 32'(e_err));
        chk({name, "/rdata"}, 32'(rdata), 32'(e_rdata));
        @(posedge Clk);
        #1;
        chk({name, "/done_off"}, 32'(done), 32'd0);
        chk({name, "/busy_off"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        string      name;
        int         id;
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wd;
        logic [3:0] e_done;
        logic [3:0] e_err;
        logic [7:0] e_rdata;
        int         e_lat;
    } vec_t;

    vec_t tbl [7];

    // Reference model state for the randomized run.
    logic [7:0]  mm [16];
    int unsigned ptr_m;
    bit          have_txn;
    int          sched_left;
    int unsigned sched_id;
    bit          sched_rd, sched_err;
    logic [7:0]  sched_rdata;
    logic [3:0]  exp_done, exp_err, prev_done, pend;
    logic [7:0]  exp_rdata;
    bit          exp_busy;

    initial begin
        req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        Rst_n = 1'b0;

        tbl[0] = '{"wr1_10",   1, 1'b0, 1'b1, 8'h10, 8'hA5, 4'b0010, 4'b0000, 8'h00, 2};
        tbl[1] = '{"rd0_10",   0, 1'b1, 1'b0, 8'h10, 8'h00, 4'b0001, 4'b0000, 8'hA5, 3};
        tbl[2] = '{"rd2_20",   2, 1'b1, 1'b0, 8'h20, 8'h00, 4'b0100, 4'b0000, 8'h3C, 3};
        tbl[3] = '{"conf1_30", 1, 1'b1, 1'b1, 8'h30, 8'h5A, 4'b0010, 4'b0010, 8'h3C, 2};
        tbl[4] = '{"rd3_30",   3, 1'b1, 1'b0, 8'h30, 8'h00, 4'b1000, 4'b0000, 8'h5A, 3};
        tbl[5] = '{"wr2_ff",   2, 1'b0, 1'b1, 8'hFF, 8'h77, 4'b0100, 4'b0000, 8'h5A, 2};
        tbl[6] = '{"rd0_ff",   0, 1'b1, 1'b0, 8'hFF, 8'h00, 4'b0001, 4'b0000, 8'h77, 3};

        // Reset values
        repeat (2) @(posedge Clk);
        #1;
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/err", 32'(err), 32'd0);
        chk("rst/rdata", 32'(rdata), 32'd0);
        chk("rst/mem_read", 32'(mem_read), 32'd0);
        chk("rst/mem_write", 32'(mem_write), 32'd0);
        chk("rst/busy", 32'(busy), 32'd0);
        Rst_n = 1'b1;
        load(8'h20, 8'h3C);

        // Vector table: single write/read, read latency, conflict
        for (int i = 0; i < 7; i++) begin
            run_one(tbl[i].name, tbl[i].id, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd,
                    tbl[i].e_done, tbl[i].e_err, tbl[i].e_rdata, tbl[i].e_lat);
        end
        chk("conf1_30/ram", 32'(ram[8'h30]), 32'h5A);

        // Reset during RDWAIT abandons the read
        set_req(0, 1'b1, 1'b0, 8'h20, 8'h00);
        @(posedge Clk); #1;
        chk("rstmid/issue", 32'(mem_read), 32'd1);
        @(posedge Clk); #1;
        chk("rstmid/rdwait_busy", 32'(busy), 32'd1);
        Rst_n = 1'b0;
        #1;
        chk("rstmid/done", 32'(done), 32'd0);
        chk("rstmid/mem_read", 32'(mem_read), 32'd0);
        chk("rstmid/mem_write", 32'(mem_write), 32'd0);
        chk("rstmid/busy", 32'(busy), 32'd0);
        chk("rstmid/rdata", 32'(rdata), 32'd0);
        req_rd = '0;
        @(posedge Clk); #1;
        chk("rstmid/no_done", 32'(done), 32'd0);
        Rst_n = 1'b1;
        run_one("rstmid/after", 0, 1'b1, 1'b0, 8'h10, 8'h00, 4'b0001, 4'b0000, 8'hA5, 3);

        // Round robin with all four reading continuously from reset
        do_reset();
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h20, 8'h00);
        set_req(2, 1'b1, 1'b0, 8'h30, 8'h00);
        set_req(3, 1'b1, 1'b0, 8'hFF, 8'h00);
        begin
            int got_id [5];
            int got_cyc [5];
            int ndone = 0;
            logic [7:0] exp_rr [4];
            exp_rr[0] = 8'hA5; exp_rr[1] = 8'h3C; exp_rr[2] = 8'h5A; exp_rr[3] = 8'h77;
            for (int c = 1; c <= 40 && ndone < 5; c++) begin
                @(posedge Clk); #1;
                if (done != '0) begin
                    got_id[ndone] = -1;
                    for (int k = 0; k < 4; k++) if (done == 4'(1 << k)) got_id[ndone] = k;
                    got_cyc[ndone] = c;
                    if (got_id[ndone] >= 0)
                        chk($sformatf("rr/rdata%0d", ndone), 32'(rdata), 32'(exp_rr[got_id[ndone]]));
                    ndone++;
                end
            end
            req_rd = '0;
            chk("rr/count", 32'(ndone), 32'd5);
            for (int k = 0; k < ndone; k++) begin
                chk($sformatf("rr/order%0d", k), 32'(got_id[k]), 32'(k % 4));
                if (k > 0) chk($sformatf("rr/spacing%0d", k), 32'(got_cyc[k] - got_cyc[k-1]), 32'd3);
            end
            repeat (4) @(posedge Clk);
        end

        // Done masking: 0 holds through its done cycle while 3 is pending
        do_reset();
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        set_req(3, 1'b1, 1'b0, 8'h30, 8'h00);
        begin
            int n = 0;
            while (done == '0 && n < 8) begin @(posedge Clk); #1 n++; end
            chk("mask/first", 32'(done), 32'b0001);
            @(posedge Clk); #1;
            chk("mask/grant3_read", 32'(mem_read), 32'd1);
            chk("mask/grant3_addr", 32'(mem_addr), 32'h30);
            set_req(0, 1'b0, 1'b0, 8'h10, 8'h00);
            n = 0;
            while (done == '0 && n < 8) begin @(posedge Clk); #1 n++; end
            chk("mask/second", 32'(done), 32'b1000);
            chk("mask/second_rdata", 32'(rdata), 32'h5A);
            set_req(3, 1'b0, 1'b0, 8'h30, 8'h00);
            // Lone writer holding in its done cycle must not be re-issued
            @(posedge Clk); #1;
            set_req(1, 1'b0, 1'b1, 8'h05, 8'hEE);
            n = 0;
            while (done == '0 && n < 8) begin @(posedge Clk); #1 n++; end
            chk("mask/lone_done", 32'(done), 32'b0010);
            @(posedge Clk); #1;
            chk("mask/lone_no_regrant", 32'(mem_write), 32'd0);
            chk("mask/lone_idle", 32'(busy), 32'd0);
            set_req(1, 1'b0, 1'b0, 8'h05, 8'hEE);
            @(posedge Clk); #1;
            chk("mask/lone_no_done", 32'(done), 32'd0);
        end

        // Randomized run against the transaction-level model
        do_reset();
        for (int a = 0; a < 16; a++) begin
            mm[a] = 8'(a * 37 + 11);
            load(8'(a), mm[a]);
        end
        ptr_m = 0; have_txn = 1'b0; sched_left = 0; sched_id = 0;
        sched_rd = 1'b0; sched_err = 1'b0; sched_rdata = '0;
        exp_done = '0; exp_err = '0; exp_rdata = '0; exp_busy = 1'b0;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            @(posedge Clk);
            prev_done = exp_done;
            exp_done  = '0;
            exp_err   = '0;
            if (have_txn) begin
                sched_left--;
                if (sched_left == 0) begin
                    exp_done[sched_id] = 1'b1;
                    exp_err[sched_id]  = sched_err;
                    if (sched_rd) exp_rdata = sched_rdata;
                    have_txn = 1'b0;
                end
            end else begin
                pend = (req_rd | req_wr) & ~prev_done;
                for (int k = 0; k < 4 && !have_txn; k++) begin
                    int unsigned id;
                    logic [7:0] a;
                    id = (ptr_m + 32'(k)) % NREQ;
                    if (pend[id]) begin
                        a = req_addr[id*AW +: AW];
                        have_txn  = 1'b1;
                        sched_id  = id;
                        sched_err = req_rd[id] & req_wr[id];
                        if (req_wr[id]) begin
                            mm[a[3:0]] = req_wdata[id*WIDTH +: WIDTH];
                            sched_rd   = 1'b0;
                            sched_left = 1;
                        end else begin
                            sched_rdata = mm[a[3:0]];
                            sched_rd    = 1'b1;
                            sched_left  = 2;
                        end
                        ptr_m = (id + 1) % NREQ;
                    end
                end
            end
            exp_busy = have_txn;
            #1;
            chk("rand/done", 32'(done), 32'(exp_done));
            chk("rand/err", 32'(err), 32'(exp_err));
            chk("rand/rdata", 32'(rdata), 32'(exp_rdata));
            chk("rand/busy", 32'(busy), 32'(exp_busy));
            for (int i = 0; i < 4; i++) begin
                if (exp_done[i]) set_req(i, 1'b0, 1'b0, 8'h00, 8'h00);
                if (!req_rd[i] && !req_wr[i] && $urandom_range(0, 3) == 0) begin
                    int unsigned r;
                    r = $urandom_range(0, 7);
                    set_req(i, (r == 0) || (r > 3), (r <= 3),
                            8'($urandom_range(0, 15)), 8'($urandom));
                end
            end
        end
        req_rd = '0;
        req_wr = '0;
        repeat (4) @(posedge Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
